// File: rtl/bisr_pkg.sv
// Shared definitions for the BIST/BISR pattern path: LFSR polynomial and seed,
// checker state encoding and error-counter width.
package bisr_pkg;

  localparam logic [15:0] LFSR_SEED = 16'h0001;
  localparam int          ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // One polynomial for both the pattern writer and the read-back checker.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

endpackage

// File: rtl/bisr_fail_fifo.sv
// Small in-order FIFO of failing addresses. A push into a full FIFO is kept
// only when a pop frees a slot in the same cycle; flush wins over both.
module bisr_fail_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/bisr_read_checker.sv
// BIST read-back checker: regenerates the LFSR pattern per accepted beat,
// counts mismatches and queues failing addresses for the repair logic.
module bisr_read_checker
  import bisr_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int NUM_WORDS  = 256,
  parameter int FAIL_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 rd_valid,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [15:0]          rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 overflow,
  output logic                 fail_valid,
  output logic [ADDR_W-1:0]    fail_addr,
  input  logic                 fail_pop
);

  localparam int               CNT_W     = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_WORDS - 1);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  state_e                 state_q, state_d;
  logic [15:0]            exp_q, exp_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;

  logic                   accept;
  logic                   mismatch;
  logic                   restart;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ADDR_W-1:0]      fifo_head;

  assign accept   = (state_q == RUN) && rd_valid;
  assign mismatch = accept && (rd_data != exp_q);
  assign restart  = start && (state_q != RUN);

  bisr_fail_fifo #(
    .DEPTH (FAIL_DEPTH),
    .WIDTH (ADDR_W)
  ) u_fail_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (mismatch),
    .pop     (fail_pop),
    .flush   (restart),
    .wr_data (rd_addr),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          exp_d      = LFSR_SEED;
          beat_cnt_d = '0;
          err_cnt_d  = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          exp_d      = lfsr16_next(exp_q);
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (mismatch) begin
            err_cnt_d = sat_inc(err_cnt_q);
            // A full FIFO only has room for this address if the head leaves now.
            if (fifo_full && !fail_pop) begin
              overflow_d = 1'b1;
            end
          end
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      exp_q      <= LFSR_SEED;
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign overflow   = overflow_q;
  assign fail_valid = !fifo_empty;
  assign fail_addr  = fifo_head;

endmodule

// File: tb/tb_bisr_read_checker.sv
// Directed/randomised bench for bisr_read_checker: a 256-word instance for most
// scenarios and a 300-word instance for error-counter saturation.
module tb_bisr_read_checker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        rd_valid = 1'b0;
  logic [8:0]  rd_addr = '0;
  logic [15:0] rd_data = '0;
  logic        fail_pop = 1'b0;

  logic       busy_a, done_a, pass_a, ovf_a, fv_a;
  logic [7:0] err_a, fa_a;
  logic       busy_b, done_b, pass_b, ovf_b, fv_b;
  logic [7:0] err_b;
  logic [8:0] fa_b;

  always #5 clk = ~clk;

  bisr_read_checker #(.ADDR_W(8), .NUM_WORDS(256), .FAIL_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .rd_valid(rd_valid),
    .rd_addr(rd_addr[7:0]), .rd_data(rd_data), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .overflow(ovf_a), .fail_valid(fv_a),
    .fail_addr(fa_a), .fail_pop(fail_pop)
  );

  bisr_read_checker #(.ADDR_W(9), .NUM_WORDS(300), .FAIL_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .overflow(ovf_b), .fail_valid(fv_b),
    .fail_addr(fa_b), .fail_pop(fail_pop)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] pat [300];
  int          k;
  int          m_err;
  bit          m_ovf;
  int          mq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int max_idle);
    int n;
    n = int'($urandom_range(0, max_idle));
    repeat (n) tick();
  endtask

  task automatic model_reset();
    k = 0;
    m_err = 0;
    m_ovf = 0;
    mq.delete();
  endtask

  task automatic pulse_start(input bit use_b);
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    model_reset();
  endtask

  // Drive one read beat; the model pops before pushing, so a full queue
  // with a simultaneous pop keeps the new address.
  task automatic beat(input int addr, input logic [15:0] data, input bit pop);
    rd_valid = 1'b1;
    rd_addr  = 9'(addr);
    rd_data  = data;
    fail_pop = pop;
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (data != pat[k]) begin
      if (m_err < 255) m_err++;
      if (mq.size() < DEPTH) mq.push_back(addr);
      else m_ovf = 1'b1;
    end
    k++;
    tick();
    rd_valid = 1'b0;
    fail_pop = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic busy, input logic done,
                           input logic pass, input logic [7:0] err, input logic ovf,
                           input logic fv, input logic [8:0] fa, input bit exp_done);
    check({tag, ".busy"}, 32'(busy), 32'(!exp_done));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".pass"}, 32'(pass), 32'(exp_done && m_err == 0));
    check({tag, ".err_cnt"}, 32'(err), 32'(m_err));
    check({tag, ".overflow"}, 32'(ovf), 32'(m_ovf));
    check({tag, ".fail_valid"}, 32'(fv), 32'(mq.size() > 0));
    if (mq.size() > 0) check({tag, ".fail_addr"}, 32'(fa), 32'(mq[0]));
  endtask

  task automatic drain_a(input string tag);
    int n;
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".drain_valid"}, 32'(fv_a), 32'(1));
      check({tag, ".drain_addr"}, 32'(fa_a), 32'(mq[0]));
      fail_pop = 1'b1;
      tick();
      fail_pop = 1'b0;
      void'(mq.pop_front());
    end
    check({tag, ".drained_empty"}, 32'(fv_a), 32'(0));
  endtask

  task automatic run_clean(input bit use_b, input int n);
    for (int i = 0; i < n; i++) begin
      gap(3);
      if (i == n - 1) check("clean.done_before_last", 32'(use_b ? done_b : done_a), 32'(0));
      beat(i, pat[i], 1'b0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".a_busy"}, 32'(busy_a), 32'(0));
    check({tag, ".a_done"}, 32'(done_a), 32'(0));
    check({tag, ".a_pass"}, 32'(pass_a), 32'(0));
    check({tag, ".a_err"}, 32'(err_a), 32'(0));
    check({tag, ".a_ovf"}, 32'(ovf_a), 32'(0));
    check({tag, ".a_fv"}, 32'(fv_a), 32'(0));
    check({tag, ".a_fa"}, 32'(fa_a), 32'(0));
    check({tag, ".b_busy"}, 32'(busy_b), 32'(0));
    check({tag, ".b_err"}, 32'(err_b), 32'(0));
    check({tag, ".b_fv"}, 32'(fv_b), 32'(0));
    check({tag, ".b_fa"}, 32'(fa_b), 32'(0));
  endtask

  initial begin
    logic [15:0] x;
    bit          bad;
    bit          pop;
    int          addr;

    x = 16'h0001;
    for (int i = 0; i < 300; i++) begin
      pat[i] = x;
      x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    end
    model_reset();

    // Reset and idle behaviour
    #2 rstn = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rstn = 1'b1;
    tick();
    rd_valid = 1'b1; rd_addr = 9'h033; rd_data = 16'hdead;
    tick();
    rd_valid = 1'b0;
    check_reset_vals("idle_ignore");

    // Clean pass with gaps
    pulse_start(1'b0);
    check("clean.busy_after_start", 32'(busy_a), 32'(1));
    run_clean(1'b0, 256);
    check_res("clean", busy_a, done_a, pass_a, err_a, ovf_a, fv_a, {1'b0, fa_a}, 1'b1);

    // Single error at beat 5, start ignored in RUN
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) beat(i, pat[i], 1'b0);
    beat(5, 16'h0000, 1'b0);
    check_res("single.at_beat", busy_a, done_a, pass_a, err_a, ovf_a, fv_a, {1'b0, fa_a}, 1'b0);
    check("single.fail_addr", 32'(fa_a), 32'h05);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_res("single.start_in_run", busy_a, done_a, pass_a, err_a, ovf_a, fv_a, {1'b0, fa_a}, 1'b0);
    for (int i = 6; i < 256; i++) begin
      gap(2);
      beat(i, pat[i], 1'b0);
    end
    check_res("single.end", busy_a, done_a, pass_a, err_a, ovf_a, fv_a, {1'b0, fa_a}, 1'b1);
    check("single.err_is_1", 32'(err_a), 32'(1));
    drain_a("single");

    // Overflow: six failing addresses, no pops
    pulse_start(1'b0);
    for (int i = 0; i < 256; i++)
      beat(i, (i >= 16 && i <= 21) ? ~pat[i] : pat[i], 1'b0);
    check_res("ovf", busy_a, done_a, pass_a, err_a, ovf_a, fv_a, {1'b0, fa_a}, 1'b1);
    check("ovf.err_is_6", 32'(err_a), 32'(6));
    drain_a("ovf");

    // Full FIFO with simultaneous push and pop
    pulse_start(1'b0);
    for (int i = 0; i < 256; i++)
      beat(i, (i >= 'h1c && i <= 'h20) ? ~pat[i] : pat[i], i == 'h20);
    check_res("fullpp", busy_a, done_a, pass_a, err_a, ovf_a, fv_a, {1'b0, fa_a}, 1'b1);
    check("fullpp.no_overflow", 32'(ovf_a), 32'(0));
    drain_a("fullpp");

    // Randomised errors, addresses and pops
    pulse_start(1'b0);
    for (int i = 0; i < 256; i++) begin
      gap(1);
      bad  = ($urandom_range(0, 7) == 0);
      pop  = ($urandom_range(0, 3) == 0);
      addr = int'($urandom_range(0, 255));
      beat(addr, bad ? (pat[i] ^ 16'($urandom_range(1, 65535))) : pat[i], pop);
    end
    check_res("rand", busy_a, done_a, pass_a, err_a, ovf_a, fv_a, {1'b0, fa_a}, 1'b1);
    rd_valid = 1'b1; rd_addr = 9'h0aa; rd_data = ~pat[0];
    tick();
    rd_valid = 1'b0;
    check_res("rand.done_ignore", busy_a, done_a, pass_a, err_a, ovf_a, fv_a, {1'b0, fa_a}, 1'b1);
    drain_a("rand");

    // Saturation on the 300-word instance, then restart and clean pass
    pulse_start(1'b1);
    for (int i = 0; i < 300; i++) beat(i, ~pat[i], 1'b0);
    check_res("sat", busy_b, done_b, pass_b, err_b, ovf_b, fv_b, fa_b, 1'b1);
    check("sat.err_255", 32'(err_b), 32'd255);
    pulse_start(1'b1);
    check_res("sat.restart", busy_b, done_b, pass_b, err_b, ovf_b, fv_b, fa_b, 1'b0);
    run_clean(1'b1, 300);
    check_res("sat.clean", busy_b, done_b, pass_b, err_b, ovf_b, fv_b, fa_b, 1'b1);

    // Reset in the middle of a pass
    pulse_start(1'b0);
    for (int i = 0; i <= 100; i++) beat(i, (i % 10 == 3) ? ~pat[i] : pat[i], 1'b0);
    check("midrst.err_before", 32'(err_a), 32'(m_err));
    rstn = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    rstn = 1'b1;
    tick();
    pulse_start(1'b0);
    run_clean(1'b0, 256);
    check_res("midrst.clean", busy_a, done_a, pass_a, err_a, ovf_a, fv_a, {1'b0, fa_a}, 1'b1);
    check("midrst.pass", 32'(pass_a), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
